// File: rtl/mipi_1lane_yuv422_tx.sv
// Single-lane CSI-2 style transmitter: YUV422 lines become FS / long packet / FE bursts on the HS byte interface.
// Define MIPI_TX_CRC_EN to emit a real CRC-16 footer; otherwise the footer is two zero bytes.
module mipi_1lane_yuv422_tx #(
  parameter int         LINE_WORDS = 1280,
  parameter logic [1:0] VC         = 2'd0,
  parameter int         GAP_CYCLES = 8
) (
  input  logic        clk_byte,
  input  logic        rst_n,
  input  logic        yuv_fv,
  input  logic        yuv_lv,
  input  logic [15:0] yuv_data,
  output logic        yuv_ready,
  output logic        tx_request_hs0,
  output logic [7:0]  tx_data_hs0,
  input  logic        tx_ready_hs0,
  output logic        line_err
);

  typedef enum logic [2:0] {IDLE, FS, LINE_WAIT, LHDR, PAYLOAD, CRC, GAP, FE} state_t;

  localparam logic [15:0] WC_LINE   = 16'(LINE_WORDS);
  localparam logic [15:0] LAST_BYTE = 16'(LINE_WORDS - 1);
  localparam logic [15:0] NPIX      = 16'(LINE_WORDS / 2);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  function automatic logic [7:0] ecc_calc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return {2'b00, p};
  endfunction

`ifdef MIPI_TX_CRC_EN
  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction
`endif

  state_t      state, nxt;
  logic [15:0] cnt;
  logic [15:0] frame_num;
  logic [15:0] pix_cnt;
  logic        fv_q;
  logic        gap_to_idle;
  logic        line_open;
  logic        long_seen;
  logic        phase;
  logic        vld_p0;
  logic [15:0] pix_p0;
  logic        pkt_state, adv, pix_open, drain, take, line_start;
  logic [7:0]  di;
  logic [15:0] wc;
`ifdef MIPI_TX_CRC_EN
  logic [15:0] crc;
`endif

  assign pkt_state  = (state == FS) || (state == LHDR) || (state == PAYLOAD) ||
                      (state == CRC) || (state == FE);
  assign adv        = pkt_state & tx_ready_hs0;
  assign pix_open   = (state == PAYLOAD) & line_open & (pix_cnt < NPIX);
  // Once a line has delivered all its pixels, anything more is swallowed until yuv_lv drops.
  assign drain      = line_open & (pix_cnt == NPIX);
  assign line_start = (state == LINE_WAIT) && (nxt == LHDR);

  always_ff @(posedge clk_byte or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:         if (yuv_fv && !fv_q) nxt = FS;
      FS, FE, LHDR: if (adv && cnt[1:0] == 2'd3) nxt = (state == LHDR) ? PAYLOAD : GAP;
      LINE_WAIT: begin
        if (yuv_lv && !line_open) nxt = LHDR;
        else if (!yuv_fv)         nxt = FE;
      end
      PAYLOAD:      if (adv && cnt == LAST_BYTE) nxt = CRC;
      CRC:          if (adv && cnt[0]) nxt = GAP;
      GAP:          if (cnt == GAP_LAST) nxt = gap_to_idle ? IDLE : LINE_WAIT;
      default:      nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_request_hs0 = pkt_state;
    tx_data_hs0    = 8'h00;
    di             = {VC, 6'h1E};
    wc             = WC_LINE;
    yuv_ready      = drain | (pix_open & ((!vld_p0 && !phase) | (vld_p0 && phase && tx_ready_hs0)));
    take           = pix_open & yuv_lv & yuv_ready;
    case (state)
      FS, FE, LHDR: begin
        if (state != LHDR) begin
          di = {VC, (state == FS) ? 6'h00 : 6'h01};
          wc = frame_num;
        end
        case (cnt[1:0])
          2'd0:    tx_data_hs0 = di;
          2'd1:    tx_data_hs0 = wc[7:0];
          2'd2:    tx_data_hs0 = wc[15:8];
          default: tx_data_hs0 = ecc_calc({wc, di});
        endcase
      end
      PAYLOAD: begin
        // With an empty holding register the C byte passes straight through from the pixel being taken.
        if (!phase) tx_data_hs0 = vld_p0 ? pix_p0[15:8] : ((pix_open && yuv_lv) ? yuv_data[15:8] : 8'h00);
        else        tx_data_hs0 = vld_p0 ? pix_p0[7:0] : 8'h00;
      end
      CRC: begin
`ifdef MIPI_TX_CRC_EN
        tx_data_hs0 = cnt[0] ? crc[15:8] : crc[7:0];
`else
        tx_data_hs0 = 8'h00;
`endif
      end
      default: tx_data_hs0 = 8'h00;
    endcase
  end

  always_ff @(posedge clk_byte or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= 16'd0;
      frame_num   <= 16'h0001;
      pix_cnt     <= 16'd0;
      fv_q        <= 1'b1;
      gap_to_idle <= 1'b0;
      line_open   <= 1'b0;
      long_seen   <= 1'b0;
      phase       <= 1'b0;
      vld_p0      <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      fv_q     <= yuv_fv;
      line_err <= 1'b0;
      if (nxt != state)                cnt <= 16'd0;
      else if (adv || state == GAP)    cnt <= cnt + 16'd1;
      if (state == FE && nxt == GAP)
        frame_num <= (frame_num == 16'hFFFF) ? 16'h0001 : frame_num + 16'd1;
      if (state != GAP && nxt == GAP)  gap_to_idle <= (state == FE);
      if (line_start) begin
        line_open <= 1'b1;
        long_seen <= 1'b0;
        pix_cnt   <= 16'd0;
      end else if (line_open) begin
        if (!yuv_lv) begin
          line_open <= 1'b0;
          line_err  <= (pix_cnt < NPIX);
        end else if (drain && !long_seen) begin
          long_seen <= 1'b1;
          line_err  <= 1'b1;
        end
        if (take) pix_cnt <= pix_cnt + 16'd1;
      end
      if (take)                                 vld_p0 <= 1'b1;
      else if (state == PAYLOAD && adv && phase) vld_p0 <= 1'b0;
      if (state != PAYLOAD) phase <= 1'b0;
      else if (adv)         phase <= ~phase;
    end
  end

  always_ff @(posedge clk_byte) begin
    if (take) pix_p0 <= yuv_data;
  end

`ifdef MIPI_TX_CRC_EN
  always_ff @(posedge clk_byte or negedge rst_n) begin
    if (!rst_n)                         crc <= 16'hFFFF;
    else if (line_start)                crc <= 16'hFFFF;
    else if (state == PAYLOAD && adv)   crc <= crc_next(crc, tx_data_hs0);
  end
`endif

endmodule

// File: tb/tb_mipi_1lane_yuv422_tx.sv
// Directed bench for mipi_1lane_yuv422_tx: frame/line packets, back-pressure, short/long lines, fv drop, reset.
module tb_mipi_1lane_yuv422_tx;
  logic        clk_byte = 1'b0;
  logic        rst_n, yuv_fv, yuv_lv, yuv_ready, tx_request_hs0, tx_ready_hs0, line_err;
  logic [15:0] yuv_data;
  logic [7:0]  tx_data_hs0;

  always #5 clk_byte = ~clk_byte;

  mipi_1lane_yuv422_tx dut (
    .clk_byte(clk_byte), .rst_n(rst_n), .yuv_fv(yuv_fv), .yuv_lv(yuv_lv), .yuv_data(yuv_data),
    .yuv_ready(yuv_ready), .tx_request_hs0(tx_request_hs0), .tx_data_hs0(tx_data_hs0),
    .tx_ready_hs0(tx_ready_hs0), .line_err(line_err)
  );

  int ntests = 0, nfail = 0;
  logic [7:0] bytes[$];
  int pkt_start[$], pkt_end[$], gaps[$];
  int npkt = 0, lowrun = 0, err_pulses = 0, err_cycles = 0, stab_bad = 0;
  bit prev_req = 0, prev_err = 0, prev_ready = 0;
  logic [7:0] prev_data = 8'h00;
  int pix_idx = 0, src_npix = 0, fv_drop_pix = 1 << 30;
  bit src_on = 0, rnd_ready = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int n);
    logic [7:0] b;
    b = n[7:0];
    return {b, ~b};
  endfunction

  task automatic drive_src();
    if (src_on) begin
      yuv_lv   = (pix_idx < src_npix);
      yuv_data = pat(pix_idx);
      if (pix_idx >= fv_drop_pix) yuv_fv = 1'b0;
    end
    tx_ready_hs0 = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic cycle();
    bit acc;
    @(negedge clk_byte);
    if (tx_request_hs0 && !prev_req) begin pkt_start.push_back(bytes.size()); gaps.push_back(lowrun); end
    if (!tx_request_hs0 && prev_req) begin pkt_end.push_back(bytes.size()); npkt++; end
    if (tx_request_hs0 && prev_req && !prev_ready && tx_data_hs0 !== prev_data) stab_bad++;
    if (tx_request_hs0 && tx_ready_hs0) bytes.push_back(tx_data_hs0);
    lowrun = tx_request_hs0 ? 0 : lowrun + 1;
    if (line_err) begin err_cycles++; if (!prev_err) err_pulses++; end
    prev_err = line_err; prev_req = tx_request_hs0; prev_ready = tx_ready_hs0; prev_data = tx_data_hs0;
    acc = yuv_lv && yuv_ready;
    @(posedge clk_byte); #1;
    if (acc) pix_idx++;
    drive_src();
  endtask

  task automatic start_line(input int npix, input bit rnd);
    pix_idx = 0; src_npix = npix; rnd_ready = rnd; src_on = 1;
    drive_src();
  endtask

  task automatic wait_pkts(input int target, input int budget, input string tag);
    int n = 0;
    while (npkt < target && n < budget) begin cycle(); n++; end
    chk({tag, "_timeout"}, 32'(npkt >= target), 32'd1);
  endtask

  task automatic check_short(input int k, input logic [31:0] exp, input string tag);
    if (pkt_end.size() <= k) begin chk({tag, "_missing"}, 32'd0, 32'd1); return; end
    chk({tag, "_len"}, pkt_end[k] - pkt_start[k], 32'd4);
    chk({tag, "_bytes"}, {bytes[pkt_start[k]], bytes[pkt_start[k]+1], bytes[pkt_start[k]+2],
                          bytes[pkt_start[k]+3]}, exp);
  endtask

  task automatic check_line(input int k, input int ndata, input string tag);
    int s, bad, p;
    logic [7:0] e;
    logic [15:0] ftr;
    logic [15:0] crc;
    if (pkt_end.size() <= k) begin chk({tag, "_missing"}, 32'd0, 32'd1); return; end
    s = pkt_start[k];
    chk({tag, "_len"}, pkt_end[k] - s, 32'd1286);
    if (pkt_end[k] - s != 1286) return;
    chk({tag, "_hdr"}, {bytes[s], bytes[s+1], bytes[s+2], bytes[s+3]}, 32'h1E00051E);
    bad = 0; crc = 16'hFFFF;
    for (int i = 0; i < 1280; i++) begin
      p = i / 2;
      e = (p < ndata) ? ((i % 2 == 0) ? pat(p) >> 8 : pat(p) & 16'h00FF) : 8'h00;
      if (bytes[s+4+i] !== e) bad++;
      crc = crc ^ {8'h00, e};
      for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 16'h8408) : (crc >> 1);
    end
    chk({tag, "_payload_bad"}, bad, 32'd0);
`ifdef MIPI_TX_CRC_EN
    ftr = {crc[7:0], crc[15:8]};
`else
    ftr = 16'h0000;
`endif
    chk({tag, "_footer"}, {bytes[s+1284], bytes[s+1285]}, ftr);
  endtask

  initial begin
    int e0, c0, nb, np, n;
    rst_n = 0; yuv_fv = 0; yuv_lv = 0; yuv_data = 16'h0; tx_ready_hs0 = 1;
    repeat (3) @(posedge clk_byte);
    #1;
    chk("rst_req", tx_request_hs0, 1'b0);
    chk("rst_data", tx_data_hs0, 8'h00);
    chk("rst_ready", yuv_ready, 1'b0);
    chk("rst_err", line_err, 1'b0);
    rst_n = 1;
    repeat (5) cycle();
    chk("idle_quiet", bytes.size(), 32'd0);

    yuv_fv = 1;
    wait_pkts(1, 50, "fs1");
    check_short(0, 32'h0001001A, "fs1");

    start_line(640, 0);
    e0 = err_pulses;
    wait_pkts(2, 3000, "full");
    check_line(1, 640, "full");
    chk("full_gap", 32'(gaps[1] >= 8), 32'd1);
    chk("full_err", err_pulses - e0, 32'd0);

    start_line(640, 1);
    stab_bad = 0; e0 = err_pulses;
    wait_pkts(3, 8000, "rand");
    check_line(2, 640, "rand");
    chk("rand_stable", stab_bad, 32'd0);
    chk("rand_err", err_pulses - e0, 32'd0);

    e0 = err_pulses; c0 = err_cycles;
    start_line(100, 0);
    wait_pkts(4, 3000, "short");
    check_line(3, 100, "short");
    chk("short_err_pulses", err_pulses - e0, 32'd1);
    chk("short_err_cycles", err_cycles - c0, 32'd1);

    e0 = err_pulses; c0 = err_cycles;
    start_line(700, 0);
    wait_pkts(5, 4000, "long");
    repeat (80) cycle();
    check_line(4, 640, "long");
    chk("long_drained", pix_idx, 32'd700);
    chk("long_err_pulses", err_pulses - e0, 32'd1);
    chk("long_err_cycles", err_cycles - c0, 32'd1);

    e0 = err_pulses;
    fv_drop_pix = 50;
    start_line(50, 0);
    wait_pkts(7, 4000, "fvdrop");
    check_line(5, 50, "fvdrop");
    chk("fvdrop_err", err_pulses - e0, 32'd1);
    check_short(6, 32'h0101001D, "fe1");
    chk("fe_gap", 32'(gaps[6] >= 8), 32'd1);
    fv_drop_pix = 1 << 30;
    repeat (20) cycle();
    chk("post_fe_quiet", pkt_start.size(), 32'd7);
    yuv_fv = 1;
    wait_pkts(8, 100, "fs2");
    check_short(7, 32'h0002001C, "fs2");

    start_line(640, 0);
    n = 0;
    while ((pkt_start.size() < 9 || bytes.size() < pkt_start[8] + 30) && n < 3000) begin cycle(); n++; end
    chk("trunc_reached", 32'(n < 3000), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("async_req", tx_request_hs0, 1'b0);
    chk("async_data", tx_data_hs0, 8'h00);
    chk("async_ready", yuv_ready, 1'b0);
    src_on = 0; yuv_lv = 0;
    repeat (3) cycle();
    rst_n = 1;
    nb = bytes.size(); np = pkt_start.size();
    repeat (40) cycle();
    chk("post_rst_bytes", bytes.size() - nb, 32'd0);
    chk("post_rst_pkts", pkt_start.size() - np, 32'd0);
    yuv_fv = 0;
    cycle();
    yuv_fv = 1;
    wait_pkts(10, 100, "fs_after_rst");
    check_short(9, 32'h0001001A, "fs_after_rst");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
